ysyx_23060072_ifu_mem_if: RTL and testbench
===========================================

YSYX_23060072_IFU_MEM_IF -- requirements
Module: ysyx_23060072_ifu_mem_if

Interface
REQ-001 Parameters SHALL be:
  NOP_INSTR, 32'h0000_0013, instruction substituted on flush, error or misalignment
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 addr_i  in  32  fetch PC from if_stage.
REQ-005 addr_valid_i  in  1  fetch request valid.
REQ-006 addr_ready_o  out  1  fetch request accepted this cycle when high with addr_valid_i.
REQ-007 clean_flag_i  in  1  flush from controller; kills the in-flight fetch.
REQ-008 instr_rdata_o  out  32  fetched instruction to if_stage.
REQ-009 instr_valid_o  out  1  instr_rdata_o valid.
REQ-010 instr_ready_i  in  1  if_stage consumes instruction.
REQ-011 fetch_err_o  out  1  qualifies instr_valid_o; the delivered word is a fault substitute.
REQ-012 mem_req_o, mem_addr_o[31:0]  out  request to instruction memory.
REQ-013 mem_gnt_i  in  1  memory accepted request.
REQ-014 mem_rvalid_i, mem_rdata_i[31:0], mem_err_i  in  memory response, one per grant, at least 1 cycle after the grant.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, HOLD; one outstanding memory transaction maximum.
REQ-016 addr_ready_o SHALL be 1 in IDLE, and 1 in HOLD only when instr_ready_i=1; otherwise 0.
REQ-017 Accept (addr_valid_i & addr_ready_o & !clean_flag_i) SHALL register addr_i into addr_q and go to REQ.
REQ-018 REQ: mem_req_o=1, mem_addr_o=addr_q held stable until mem_gnt_i; the request is never withdrawn; on grant go to WAIT.
REQ-019 WAIT: on mem_rvalid_i SHALL capture mem_rdata_i (or NOP_INSTR if mem_err_i), set err_q=mem_err_i, go to HOLD; if drop flag set, discard the response, clear drop, go to IDLE.
REQ-020 HOLD: instr_valid_o = !clean_flag_i; data and fetch_err_o stable until handshake; on instr_ready_i go to IDLE, or to REQ if a new accept occurs in the same cycle.
REQ-021 Minimum latency: accept at cycle N, mem_req_o at N+1, grant at N+1, rvalid at N+2, instr_valid_o at N+3.
REQ-022 clean_flag_i in REQ or WAIT SHALL set drop; the response is consumed silently and instr_valid_o never rises for that fetch.
REQ-023 clean_flag_i in HOLD SHALL discard the held word, go to IDLE and load instr_rdata_o with NOP_INSTR.
REQ-024 clean_flag_i together with addr_valid_i SHALL NOT accept the address.
REQ-025 clean_flag_i with mem_rvalid_i in the same WAIT cycle SHALL discard that response and go to IDLE.
REQ-026 mem_rvalid_i in IDLE, REQ or HOLD SHALL be ignored.
REQ-027 instr_rdata_o SHALL hold its last value when not valid.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, drop=0, addr_q=0, err_q=0.
REQ-029 rst_n=0 SHALL immediately force mem_req_o=0, mem_addr_o=0, instr_valid_o=0, fetch_err_o=0, instr_rdata_o=NOP_INSTR.
REQ-030 Reset mid-transaction SHALL abandon it; a late response after reset release falls under REQ-026.

Configuration
REQ-031 Macro YSYX_23060072_IFU_ALIGN_CHK_EN defined: an accept with addr_i[1:0]!=0 SHALL issue no memory request.
REQ-032 With the macro defined, a misaligned accept SHALL go directly to HOLD next cycle with NOP_INSTR and fetch_err_o=1.
REQ-033 Macro undefined: mem_addr_o[1:0] SHALL be forced to 2'b00 and no alignment error is raised.

Verification
REQ-034 Reset release, addr_i=0x0000_0010 valid, grant immediate, rvalid 1 cycle later with 0x00500093 -> instr_valid_o at accept+3, data 0x00500093, fetch_err_o=0.
REQ-035 mem_gnt_i delayed 4 cycles -> mem_req_o and mem_addr_o=0x10 stable for all 5 cycles; exactly one grant consumed.
REQ-036 clean_flag_i pulsed in WAIT, rvalid later with 0xDEADBEEF -> instr_valid_o stays 0; the next fetch returns its own data.
REQ-037 mem_err_i=1 with rvalid -> instr_rdata_o=0x00000013, fetch_err_o=1, held while instr_ready_i=0 for 3 cycles.
REQ-038 rst_n asserted in REQ -> mem_req_o=0 immediately; a stale rvalid after release is ignored.
REQ-039 Macro defined, addr_i=0x0000_0012 -> no mem_req_o; instr_valid_o next cycle with 0x00000013 and fetch_err_o=1. Macro undefined, same address -> mem_addr_o=0x0000_0010.

Source files
------------

// File: rtl/ysyx_23060072_ifu_mem_if.sv
// ysyx_23060072_ifu_mem_if: single-outstanding fetch bridge between if_stage and instruction memory.
// Define YSYX_23060072_IFU_ALIGN_CHK_EN to fault misaligned fetches without issuing a memory request.
module ysyx_23060072_ifu_mem_if #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic        addr_valid_i,
    output logic        addr_ready_o,
    input  logic        clean_flag_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        fetch_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t      r_state;
    logic        r_drop;
    logic [31:0] r_addr;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_misalign;
    assign addr_ready_o  = (r_state == IDLE) | ((r_state == HOLD) & instr_ready_i);
    assign w_accept      = addr_valid_i & addr_ready_o & ~clean_flag_i;
    assign mem_req_o     = r_state == REQ;
    assign instr_valid_o = (r_state == HOLD) & ~clean_flag_i;
    assign fetch_err_o   = instr_valid_o & r_err;
    assign instr_rdata_o = r_rdata;
`ifdef YSYX_23060072_IFU_ALIGN_CHK_EN
    assign w_misalign = addr_i[1:0] != 2'b00;
    assign mem_addr_o = r_addr;
`else
    assign w_misalign = 1'b0;
    assign mem_addr_o = r_addr & 32'hFFFF_FFFC;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
            r_addr  <= 32'h0;
            r_err   <= 1'b0;
            r_rdata <= NOP_INSTR;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (r_state == HOLD && clean_flag_i) begin
                        r_state <= IDLE;
                        r_rdata <= NOP_INSTR;
                        r_err   <= 1'b0;
                    end else if (w_accept) begin
                        r_addr <= addr_i;
                        if (w_misalign) begin
                            r_state <= HOLD;
                            r_rdata <= NOP_INSTR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= REQ;
                        end
                    end else if (r_state == HOLD && instr_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (clean_flag_i) r_drop <= 1'b1;
                    if (mem_gnt_i) r_state <= WAIT;
                end
                WAIT: begin
                    // A flushed fetch still owns the bus until its response drains.
                    if (mem_rvalid_i) begin
                        r_drop <= 1'b0;
                        if (r_drop || clean_flag_i) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= HOLD;
                            r_rdata <= mem_err_i ? NOP_INSTR : mem_rdata_i;
                            r_err   <= mem_err_i;
                        end
                    end else if (clean_flag_i) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060072_ifu_mem_if.sv
// tb_ysyx_23060072_ifu_mem_if: cycle-scripted vectors plus hand sequences for the fetch bridge.
module tb_ysyx_23060072_ifu_mem_if;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_i = '0;
    logic        addr_valid_i = 1'b0;
    logic        addr_ready_o;
    logic        clean_flag_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        fetch_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ysyx_23060072_ifu_mem_if dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .addr_valid_i(addr_valid_i),
        .addr_ready_o(addr_ready_o), .clean_flag_i(clean_flag_i), .instr_rdata_o(instr_rdata_o),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .fetch_err_o(fetch_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    typedef struct packed {
        logic        av;
        logic [31:0] ad;
        logic        cl;
        logic        ir;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        er;
        logic        e_ardy;
        logic        e_req;
        logic [31:0] e_maddr;
        logic        e_vld;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t v(input logic av, input logic [31:0] ad, input logic cl, ir, gnt, rv,
                               input logic [31:0] rd, input logic er, input logic e_ardy, e_req,
                               input logic [31:0] e_maddr, input logic e_vld,
                               input logic [31:0] e_rdata, input logic e_err);
        v = {av, ad, cl, ir, gnt, rv, rd, er, e_ardy, e_req, e_maddr, e_vld, e_rdata, e_err};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic set(input logic av, input logic [31:0] ad, input logic cl, ir, gnt, rv,
                       input logic [31:0] rd, input logic er);
        addr_valid_i = av; addr_i = ad; clean_flag_i = cl; instr_ready_i = ir;
        mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // av  addr  cl ir gnt rv rdata  er | ardy req maddr vld rdata err
        tv.push_back(v(1, 32'h10, 0, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 1, 0, 0, 0,             0, 1, 32'h10, 0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 1, 32'h00500093, 0,  0, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 1, 0, 0, 0, 0,             1, 0, 0,     1, 32'h00500093, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             1, 0, 0,     0, 32'h00500093, 0));
        tv.push_back(v(1, 32'h20, 0, 0, 0, 0, 0, 0,             1, 0, 0,     0, 32'h00500093, 0));
        tv.push_back(v(0, 0,      0, 0, 1, 0, 0, 0,             0, 1, 32'h20, 0, 32'h00500093, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 1, 32'h12345678, 1,  0, 0, 0,     0, 32'h00500093, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             0, 0, 0,     1, NOP, 1));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             0, 0, 0,     1, NOP, 1));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             0, 0, 0,     1, NOP, 1));
        tv.push_back(v(1, 32'h30, 0, 1, 0, 0, 0, 0,             1, 0, 0,     1, NOP, 1));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             0, 1, 32'h30, 0, NOP, 0));
        tv.push_back(v(0, 0,      1, 0, 1, 0, 0, 0,             0, 1, 32'h30, 0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 1, 32'hDEADBEEF, 0,  0, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));
        tv.push_back(v(1, 32'h40, 1, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 1, 32'hAAAAAAAA, 0,  1, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));
        tv.push_back(v(1, 32'h50, 0, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 1, 0, 0, 0,             0, 1, 32'h50, 0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 1, 32'h11111111, 0,  0, 0, 0,     0, NOP, 0));
        tv.push_back(v(1, 32'h60, 1, 1, 0, 0, 0, 0,             1, 0, 0,     0, 32'h11111111, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));
        tv.push_back(v(1, 32'h70, 0, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 1, 0, 0, 0,             0, 1, 32'h70, 0, NOP, 0));
        tv.push_back(v(0, 0,      1, 0, 0, 1, 32'h22222222, 0,  0, 0, 0,     0, NOP, 0));
        tv.push_back(v(0, 0,      0, 0, 0, 0, 0, 0,             1, 0, 0,     0, NOP, 0));

        step();
        chk("rst.ardy", addr_ready_o, 1);
        chk("rst.req", mem_req_o, 0);
        chk("rst.maddr", mem_addr_o, 0);
        chk("rst.vld", instr_valid_o, 0);
        chk("rst.err", fetch_err_o, 0);
        chk("rst.rdata", instr_rdata_o, NOP);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            set(tv[i].av, tv[i].ad, tv[i].cl, tv[i].ir, tv[i].gnt, tv[i].rv, tv[i].rd, tv[i].er);
            chk($sformatf("v%0d.ardy", i), addr_ready_o, tv[i].e_ardy);
            chk($sformatf("v%0d.req", i), mem_req_o, tv[i].e_req);
            chk($sformatf("v%0d.vld", i), instr_valid_o, tv[i].e_vld);
            chk($sformatf("v%0d.rdata", i), instr_rdata_o, tv[i].e_rdata);
            if (tv[i].e_req) chk($sformatf("v%0d.maddr", i), mem_addr_o, tv[i].e_maddr);
            if (tv[i].e_vld) chk($sformatf("v%0d.err", i), fetch_err_o, tv[i].e_err);
            step();
        end

        // grant held off for four cycles: request and address must not move
        set(1, 32'h10, 0, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            set(0, 0, 0, 0, k == 4, 0, 0, 0);
            chk($sformatf("dly%0d.req", k), mem_req_o, 1);
            chk($sformatf("dly%0d.maddr", k), mem_addr_o, 32'h10);
            step();
        end
        set(0, 0, 0, 0, 1, 0, 0, 0);
        chk("dly.req_off", mem_req_o, 0);
        step();
        set(0, 0, 0, 0, 0, 1, 32'h00A00113, 0);
        chk("dly.no_vld", instr_valid_o, 0);
        step();
        set(0, 0, 0, 1, 0, 0, 0, 0);
        chk("dly.vld", instr_valid_o, 1);
        chk("dly.rdata", instr_rdata_o, 32'h00A00113);
        step();

        // flush pulsed while waiting; the late response must be swallowed
        set(1, 32'h80, 0, 0, 0, 0, 0, 0);
        step();
        set(0, 0, 0, 0, 1, 0, 0, 0);
        step();
        set(0, 0, 1, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            set(0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("fl%0d.vld", k), instr_valid_o, 0);
            step();
        end
        set(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        step();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl.vld_after", instr_valid_o, 0);
        chk("fl.ardy_after", addr_ready_o, 1);
        set(1, 32'h84, 0, 0, 0, 0, 0, 0);
        step();
        set(0, 0, 0, 0, 1, 0, 0, 0);
        chk("fl.next_maddr", mem_addr_o, 32'h84);
        step();
        set(0, 0, 0, 0, 0, 1, 32'h00200093, 0);
        step();
        set(0, 0, 0, 1, 0, 0, 0, 0);
        chk("fl.next_vld", instr_valid_o, 1);
        chk("fl.next_rdata", instr_rdata_o, 32'h00200093);
        step();

        // asynchronous reset while requesting, then a stale response
        set(1, 32'h90, 0, 0, 0, 0, 0, 0);
        step();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ar.req_before", mem_req_o, 1);
        rst_n = 1'b0;
        #1;
        chk("ar.req", mem_req_o, 0);
        chk("ar.maddr", mem_addr_o, 0);
        chk("ar.rdata", instr_rdata_o, NOP);
        chk("ar.ardy", addr_ready_o, 1);
        step();
        rst_n = 1'b1;
        set(0, 0, 0, 0, 0, 1, 32'h55555555, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            set(0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("ar%0d.vld", k), instr_valid_o, 0);
            chk($sformatf("ar%0d.ardy", k), addr_ready_o, 1);
            step();
        end

        // misaligned fetch
        set(1, 32'h12, 0, 0, 0, 0, 0, 0);
        step();
`ifdef YSYX_23060072_IFU_ALIGN_CHK_EN
        set(0, 0, 0, 1, 0, 0, 0, 0);
        chk("mis.req", mem_req_o, 0);
        chk("mis.vld", instr_valid_o, 1);
        chk("mis.rdata", instr_rdata_o, NOP);
        chk("mis.err", fetch_err_o, 1);
        step();
`else
        set(0, 0, 0, 0, 1, 0, 0, 0);
        chk("mis.req", mem_req_o, 1);
        chk("mis.maddr", mem_addr_o, 32'h10);
        step();
        set(0, 0, 0, 0, 0, 1, 32'h00300093, 0);
        step();
        set(0, 0, 0, 1, 0, 0, 0, 0);
        chk("mis.vld", instr_valid_o, 1);
        chk("mis.err", fetch_err_o, 0);
        chk("mis.rdata", instr_rdata_o, 32'h00300093);
        step();
`endif
        set(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mis.done", instr_valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
